// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that feeds two requesters into one 8-deep FIFO.
// Each granted write takes one WRITE cycle, and the FIFO status is tallied in the CHECK cycle after it.
module fifo_wr_arb #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [31:0]      d0,
   input  logic [31:0]      d1,
   input  logic             fifo_full,
   input  logic             fifo_wr_ack,
   input  logic             fifo_wr_err,
   output logic             fifo_wr_en,
   output logic [31:0]      fifo_d_in,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic [CNT_W-1:0] ok_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a requester keeps reqN/dN stable until it samples gntN=1 at a rising edge.
   // gntN is a one-cycle pulse, and it coincides with fifo_wr_en and the captured data.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_go;
   logic              w_pick1;
   logic              r_last;
   logic              r_wr_en;
   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_busy;
   logic [31:0]       r_d_in;
   logic [CNT_W-1:0]  r_ok_cnt;
   logic [CNT_W-1:0]  r_err_cnt;

   always_comb begin
      w_next_state = ST_IDLE;
      w_go         = 1'b0;
      w_pick1      = 1'b0;
      case (r_state)
         ST_WRITE: w_next_state = ST_CHECK;
         default: begin
            if (!fifo_full && (req0 || req1)) begin
               w_go         = 1'b1;
               w_next_state = ST_WRITE;
            end
         end
      endcase
      // On a tie, requester 1 wins only when requester 0 was granted most recently.
      w_pick1 = req1 && (!req0 || !r_last);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_last    <= 1'b1;
         r_wr_en   <= 1'b0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_busy    <= 1'b0;
         r_d_in    <= '0;
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         r_wr_en <= w_go;
         r_gnt0  <= w_go && !w_pick1;
         r_gnt1  <= w_go && w_pick1;
         r_busy  <= (w_next_state != ST_IDLE);
         r_d_in  <= w_go ? (w_pick1 ? d1 : d0) : 32'd0;
         if (w_go) begin
            r_last <= w_pick1;
         end
         // An error takes precedence over an ack reported in the same cycle.
         if (r_state == ST_CHECK) begin
            if (fifo_wr_err) begin
               if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end else if (fifo_wr_ack) begin
               if (!(&r_ok_cnt)) r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign fifo_wr_en  = r_wr_en;
   assign fifo_d_in   = r_d_in;
   assign gnt0        = r_gnt0;
   assign gnt1        = r_gnt1;
   assign busy        = r_busy;
   assign ok_cnt      = r_ok_cnt;
   assign err_cnt     = r_err_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb. Requester and FIFO models drive the DUT, and a negedge monitor scores grants, data and counters.
// A second instance with CNT_W=2 shares every input so that counter saturation can be observed.
module tb_fifo_wr_arb;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, req0, req1, fifo_full, fifo_wr_ack, fifo_wr_err;
   logic [31:0] d0, d1;
   logic        fifo_wr_en, gnt0, gnt1, busy;
   logic [31:0] fifo_d_in;
   logic [7:0]  ok_cnt, err_cnt;
   logic [1:0]  dbg_state;
   logic        n_wr_en, n_gnt0, n_gnt1, n_busy;
   logic [31:0] n_d_in;
   logic [1:0]  n_ok_cnt, n_err_cnt, n_dbg_state;

   fifo_wr_arb #(.CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
      .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err),
      .fifo_wr_en(fifo_wr_en), .fifo_d_in(fifo_d_in), .gnt0(gnt0), .gnt1(gnt1),
      .busy(busy), .ok_cnt(ok_cnt), .err_cnt(err_cnt), .o_dbg_state(dbg_state)
   );

   fifo_wr_arb #(.CNT_W(2)) dut_s (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
      .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err),
      .fifo_wr_en(n_wr_en), .fifo_d_in(n_d_in), .gnt0(n_gnt0), .gnt1(n_gnt1),
      .busy(n_busy), .ok_cnt(n_ok_cnt), .err_cnt(n_err_cnt), .o_dbg_state(n_dbg_state)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [31:0] back0[$];
   logic [31:0] back1[$];
   int          grant_log[$];
   int          gnt1_count = 0;
   int          last_id = 1;
   int          fifo_cnt = 0;
   bit          rd_req = 0;
   bit          rand_rd = 0;
   bit          junk_en = 0;
   int          st_mode = 0;
   int          ok_raw = 0, err_raw = 0, pend_ok = 0, pend_err = 0;
   // Values seen at the previous negedge, i.e. what the DUT samples at the next rising edge.
   logic        s_req0 = 0, s_req1 = 0, s_full = 0, s_wr = 0, s_gnt0 = 0, s_gnt1 = 0, s_rst = 0;
   bit          m_prev_wr = 0;

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One clock: the FIFO, the status source and both requesters react to what they saw before the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (s_wr && fifo_cnt < 8) fifo_cnt++;
      if (rd_req && fifo_cnt > 0) fifo_cnt--;
      rd_req = 0;
      if (rand_rd && fifo_cnt > 0 && $urandom_range(0, 2) == 0) fifo_cnt--;
      if (!s_rst) begin
         ok_raw = 0; err_raw = 0; pend_ok = 0; pend_err = 0;
      end else begin
         ok_raw += pend_ok; err_raw += pend_err; pend_ok = 0; pend_err = 0;
      end
      fifo_wr_ack = 1'b0;
      fifo_wr_err = 1'b0;
      if (s_wr && s_rst) begin
         case (st_mode)
            0: fifo_wr_ack = 1'b1;
            1: fifo_wr_err = 1'b1;
            default: {fifo_wr_ack, fifo_wr_err} = 2'($urandom_range(0, 3));
         endcase
         pend_err = fifo_wr_err ? 1 : 0;
         pend_ok  = (fifo_wr_ack && !fifo_wr_err) ? 1 : 0;
      end else if (junk_en) begin
         {fifo_wr_ack, fifo_wr_err} = 2'($urandom_range(0, 3));
      end
      if (req0 && s_gnt0) req0 = 1'b0;
      if (req1 && s_gnt1) req1 = 1'b0;
      if (!req0 && back0.size() != 0) begin
         d0 = back0.pop_front(); exp_q0.push_back(d0); req0 = 1'b1;
      end
      if (!req1 && back1.size() != 0) begin
         d1 = back1.pop_front(); exp_q1.push_back(d1); req1 = 1'b1;
      end
      fifo_full = (fifo_cnt >= 8);
   endtask

   task automatic wait_drain(input int max_cyc, input string name);
      int n;
      n = 0;
      while ((back0.size() != 0 || back1.size() != 0 || exp_q0.size() != 0 ||
              exp_q1.size() != 0 || req0 || req1 || busy) && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL %s drain did not finish after %0d cycles", name, n);
      end
      tick();
      tick();
   endtask

   // Monitor: pops the scoreboard on every grant and checks every output against the model.
   initial begin
      bit exp_wr;
      bit exp_busy;
      int win;
      logic [31:0] e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_wr = s_rst && !m_prev_wr && !s_full && (s_req0 || s_req1);
         chk("wr_en", fifo_wr_en, exp_wr);
         if (exp_wr) begin
            if (s_req0 && s_req1) win = (last_id == 1) ? 0 : 1;
            else                  win = s_req0 ? 0 : 1;
            chk("gnt0", gnt0, (win == 0));
            chk("gnt1", gnt1, (win == 1));
         end else begin
            chk("gnt0_idle", gnt0, 0);
            chk("gnt1_idle", gnt1, 0);
            chk("d_in_idle", fifo_d_in, 0);
         end
         exp_busy = exp_wr || (m_prev_wr && s_rst);
         chk("busy", busy, exp_busy);
         if (gnt0) begin
            grant_log.push_back(0);
            last_id = 0;
            if (exp_q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb0 grant with no pending request, d_in=%h", fifo_d_in);
            end else begin
               e = exp_q0.pop_front();
               chk("sb0_data", fifo_d_in, e);
            end
         end
         if (gnt1) begin
            grant_log.push_back(1);
            last_id = 1;
            gnt1_count++;
            if (exp_q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb1 grant with no pending request, d_in=%h", fifo_d_in);
            end else begin
               e = exp_q1.pop_front();
               chk("sb1_data", fifo_d_in, e);
            end
         end
         chk("ok_cnt", ok_cnt, sat(ok_raw, 255));
         chk("err_cnt", err_cnt, sat(err_raw, 255));
         chk("ok_cnt_w2", n_ok_cnt, sat(ok_raw, 3));
         chk("err_cnt_w2", n_err_cnt, sat(err_raw, 3));
         if (!reset_n) last_id = 1;
         m_prev_wr = exp_wr;
         s_req0 = req0; s_req1 = req1; s_full = fifo_full;
         s_wr = fifo_wr_en; s_gnt0 = gnt0; s_gnt1 = gnt1; s_rst = reset_n;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int g1base;
      int n;
      reset_n = 0; req0 = 0; req1 = 0; d0 = '0; d1 = '0;
      fifo_full = 0; fifo_wr_ack = 0; fifo_wr_err = 0;
      repeat (3) tick();
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_busy", busy, 0);
      reset_n = 1;
      tick();

      // A single writer: it is granted in the next cycle, and its ack is counted in CHECK.
      back0.push_back(32'hA5A5_0001);
      wait_drain(50, "single");
      chk("single_ok_cnt", ok_cnt, 1);

      // Contention after reset: both requesters re-raise right away, so grants must alternate 0,1,0,1.
      reset_n = 0;
      back0.push_back(32'hA000_0000); back0.push_back(32'hA000_0001);
      back1.push_back(32'hB000_0000); back1.push_back(32'hB000_0001);
      base = grant_log.size();
      tick(); tick();
      reset_n = 1;
      wait_drain(100, "contend");
      chk("contend_n", grant_log.size() - base, 4);
      if (grant_log.size() - base == 4) begin
         chk("contend_g0", grant_log[base],     0);
         chk("contend_g1", grant_log[base + 1], 1);
         chk("contend_g2", grant_log[base + 2], 0);
         chk("contend_g3", grant_log[base + 3], 1);
      end
      chk("contend_ok_cnt", ok_cnt, 4);

      // While the FIFO is full, requests wait; a request withdrawn meanwhile is simply dropped.
      fifo_cnt = 8;
      g1base = gnt1_count;
      back1.push_back(32'h0000_BEEF);
      back0.push_back(32'hDEAD_0000);
      repeat (10) tick();
      req0 = 1'b0;
      void'(exp_q0.pop_back());
      repeat (4) tick();
      chk("full_no_gnt", gnt1_count - g1base, 0);
      rd_req = 1;
      wait_drain(50, "full");
      chk("full_gnt1_once", gnt1_count - g1base, 1);
      chk("full_fifo_cnt", fifo_cnt, 8);
      chk("full_ok_cnt", ok_cnt, 5);
      fifo_cnt = 0;
      tick();

      // The error path, including saturation of the 2-bit counter after 5 errors.
      st_mode = 1;
      back0.push_back(32'hE000_0000);
      wait_drain(50, "err1");
      chk("err1_err_cnt", err_cnt, 1);
      chk("err1_ok_cnt", ok_cnt, 5);
      for (int i = 1; i < 5; i++) back0.push_back(32'hE000_0000 + 32'(i));
      wait_drain(100, "err5");
      chk("err5_err_cnt", err_cnt, 5);
      chk("err5_sat_err_cnt", n_err_cnt, 3);
      chk("err5_sat_ok_cnt", n_ok_cnt, 3);
      st_mode = 0;

      // A reset during WRITE aborts the write, and requester 0 wins the first tie afterwards.
      back0.push_back(32'hC000_0000);
      n = 0;
      while (!fifo_wr_en && n < 20) begin tick(); n++; end
      chk("midrst_found_write", fifo_wr_en, 1);
      reset_n = 0;
      tick();
      chk("midrst_wr_en", fifo_wr_en, 0);
      chk("midrst_gnt0", gnt0, 0);
      chk("midrst_d_in", fifo_d_in, 0);
      chk("midrst_ok_cnt", ok_cnt, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      base = grant_log.size();
      back0.push_back(32'hC000_0001);
      back1.push_back(32'hC100_0001);
      tick();
      reset_n = 1;
      wait_drain(50, "midrst");
      chk("midrst_n", grant_log.size() - base, 2);
      if (grant_log.size() - base >= 1) chk("midrst_first_gnt", grant_log[base], 0);

      // Random traffic with reads, random status and spurious status values outside CHECK.
      st_mode = 2; junk_en = 1; rand_rd = 1;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0 && back0.size() < 3) back0.push_back($urandom());
         if ($urandom_range(0, 3) == 0 && back1.size() < 3) back1.push_back($urandom());
         tick();
      end
      wait_drain(500, "random");
      junk_en = 0; st_mode = 0; rand_rd = 0;
      tick();
      chk("end_q0_empty", exp_q0.size(), 0);
      chk("end_q1_empty", exp_q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter CNT_W, default 8, width of the ok_cnt and err_cnt statistics counters.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  write requests; requester holds req and data until it samples its gnt high.
REQ-005 d0, d1  input  32 each  write data of requester 0 and requester 1.
REQ-006 fifo_full  input  1  full flag from the 8-deep FIFO.
REQ-007 fifo_wr_ack, fifo_wr_err  input  1 each  FIFO write status, valid in the cycle after a write.
REQ-008 fifo_wr_en  output  1  write enable to the FIFO.
REQ-009 fifo_d_in  output  32  write data to the FIFO.
REQ-010 gnt0, gnt1  output  1 each  one-cycle grant pulses.
REQ-011 busy  output  1  high when the FSM is not in IDLE.
REQ-012 ok_cnt, err_cnt  output  CNT_W each  acknowledged and errored write counts.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 The FSM SHALL have three states: IDLE, WRITE and CHECK.
REQ-015 In IDLE or CHECK, at a clock edge with fifo_full=0 and (req0 or req1)=1, the FSM SHALL go to WRITE; otherwise it SHALL go to IDLE.
REQ-016 WRITE SHALL last exactly one cycle, then go to CHECK unconditionally.
REQ-017 During WRITE: fifo_wr_en=1; exactly one of gnt0 or gnt1 =1; fifo_d_in = the data of the granted requester, captured at the entry edge.
REQ-018 Outside WRITE: fifo_wr_en=0, gnt0=0, gnt1=0 and fifo_d_in=0.
REQ-019 Arbitration SHALL be round-robin.
  - When only one request is present, that requester SHALL win.
  - When both requests are present, the requester not granted most recently SHALL win.
  - A 1-bit last-grant pointer SHALL update only on a grant.
REQ-020 Latency: a request sampled at edge N, with the FIFO not full, SHALL produce gnt and fifo_wr_en in the cycle following edge N.
REQ-021 Maximum throughput SHALL be one write per 2 cycles (WRITE, CHECK, WRITE, ...).
REQ-022 In CHECK, fifo_wr_ack=1 SHALL increment ok_cnt and fifo_wr_err=1 SHALL increment err_cnt; both counters saturate at 2^CNT_W-1.
REQ-023 If both fifo_wr_ack and fifo_wr_err are 1 in CHECK, only err_cnt SHALL increment.
REQ-024 Status inputs SHALL be ignored outside CHECK.
REQ-025 When fifo_full=1, no grant SHALL issue; requests stay pending and are served after full deasserts, with no loss and no duplication.
REQ-026 The decision in CHECK SHALL use the fifo_full value present in CHECK, which already reflects the write just committed.
REQ-027 A requester whose req drops before it is granted SHALL simply not be served; no error is flagged.
REQ-028 busy=1 in WRITE and CHECK, and busy=0 in IDLE.

Reset
REQ-029 At any edge with reset_n=0, the block SHALL set:
  - state=IDLE;
  - last-grant pointer=1, so req0 wins the first tie;
  - fifo_wr_en, gnt0, gnt1 and busy =0;
  - fifo_d_in=0;
  - ok_cnt and err_cnt =0.
REQ-030 A reset asserted in WRITE or CHECK SHALL abort the transaction: no counter update and no pending grant after reset release.
REQ-031 The first grant after reset release SHALL be possible in the cycle after the first edge with reset_n=1 and a request present.

Verification
REQ-032 Single writer: req0=1, d0=32'hA5A5_0001, FIFO empty -> next cycle gnt0=1, fifo_wr_en=1, fifo_d_in=32'hA5A5_0001; next cycle busy=1, ack counted, ok_cnt=1.
REQ-033 Contention: req0=req1=1 held, re-raised after each grant, for 4 grants after reset -> grant order 0,1,0,1; fifo_wr_en asserted every 2nd cycle; ok_cnt=4.
REQ-034 Full backpressure:
  - Stimulus: fill the FIFO to 8 entries; hold req1 with d1=32'h0000_BEEF.
  - Response: no gnt while full.
  - Stimulus: one FIFO read.
  - Response: gnt1 exactly once and 32'h0000_BEEF written once.
REQ-035 Error path: force fifo_wr_err=1 in CHECK -> err_cnt=1 and ok_cnt unchanged; with CNT_W=2 and 5 errors, err_cnt=3 (saturated).
REQ-036 Mid-op reset: reset_n=0 during WRITE -> next cycle all outputs 0 and counters 0; after release with req0=req1=1, gnt0 wins first.
